// File: rtl/psum_acc.sv
// psum_acc: drains the output FIFO, sums acc_len consecutive rows of col
// signed partial sums lane by lane, applies optional ReLU and signed
// saturation, and hands each finished vector to the SRAM writer.
//
// Output handshake: out_data/out_valid are held stable while out_valid=1 and
// out_ready=0; a vector is transferred on a rising edge where both are 1.
// The FIFO side has no ready: ofifo_rd is a one-cycle pop request that is
// only raised while ofifo_valid=1 in FETCH.
module psum_acc #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int acc_len = 9,
    parameter int acc_bw  = 20,
    parameter int n_out   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   relu_en,
    input  logic [psum_bw*col-1:0] ofifo_out,
    input  logic                   ofifo_valid,
    output logic                   ofifo_rd,
    output logic [psum_bw*col-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             state_dbg
);

    localparam logic [1:0] st_idle  = 2'd0;
    localparam logic [1:0] st_fetch = 2'd1;
    localparam logic [1:0] st_gap   = 2'd2;
    localparam logic [1:0] st_emit  = 2'd3;

    localparam logic [4:0]  last_row = 5'(acc_len - 1);
    localparam logic [15:0] last_out = 16'(n_out - 1);

    // Saturation bounds expressed at accumulator width; the low bound is the
    // bitwise complement of the high bound (two's complement).
    localparam logic signed [acc_bw-1:0] sat_hi = acc_bw'((1 << (psum_bw - 1)) - 1);
    localparam logic signed [acc_bw-1:0] sat_lo = ~sat_hi;

    logic [1:0]               state;
    logic [4:0]               row_cnt;
    logic [15:0]              out_cnt;
    logic                     relu_q;
    logic signed [acc_bw-1:0] acc [col];

    logic signed [acc_bw-1:0] ext [col];
    logic signed [acc_bw-1:0] sum [col];
    logic signed [acc_bw-1:0] rel [col];
    logic [psum_bw*col-1:0]   fin_data;

    assign ofifo_rd  = (state == st_fetch) && ofifo_valid;
    assign busy      = (state != st_idle);
    assign state_dbg = state;

    // Per-lane next accumulator value and the finished (ReLU + saturated) lane.
    // The first row of a vector replaces the accumulator instead of adding.
    always_comb begin
        fin_data = '0;
        for (int i = 0; i < col; i++) begin
            ext[i] = {{(acc_bw - psum_bw){ofifo_out[psum_bw*i + psum_bw - 1]}},
                      ofifo_out[psum_bw*i +: psum_bw]};
            sum[i] = (row_cnt == 5'd0) ? ext[i] : acc[i] + ext[i];
            rel[i] = (relu_q && sum[i][acc_bw-1]) ? '0 : sum[i];
            if (rel[i] > sat_hi) begin
                fin_data[psum_bw*i +: psum_bw] = sat_hi[psum_bw-1:0];
            end else if (rel[i] < sat_lo) begin
                fin_data[psum_bw*i +: psum_bw] = sat_lo[psum_bw-1:0];
            end else begin
                fin_data[psum_bw*i +: psum_bw] = rel[i][psum_bw-1:0];
            end
        end
    end

    // Control FSM: fetch rows with a one-cycle gap between pops, then emit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= st_idle;
            row_cnt   <= '0;
            out_cnt   <= '0;
            relu_q    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                st_idle: begin
                    if (start) begin
                        state   <= st_fetch;
                        row_cnt <= '0;
                        out_cnt <= '0;
                        relu_q  <= relu_en;
                    end
                end
                st_fetch: begin
                    if (ofifo_valid) begin
                        if (row_cnt == last_row) begin
                            out_data  <= fin_data;
                            out_valid <= 1'b1;
                            row_cnt   <= '0;
                            state     <= st_emit;
                        end else begin
                            row_cnt <= row_cnt + 5'd1;
                            state   <= st_gap;
                        end
                    end
                end
                st_gap: begin
                    // The FIFO pops one cycle after it registers ofifo_rd.
                    state <= st_fetch;
                end
                st_emit: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_cnt == last_out) begin
                            done  <= 1'b1;
                            state <= st_idle;
                        end else begin
                            out_cnt <= out_cnt + 16'd1;
                            state   <= st_fetch;
                        end
                    end
                end
                default: state <= st_idle;
            endcase
        end
    end

    // Accumulator lanes load on every captured row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < col; i++) acc[i] <= '0;
        end else if (ofifo_rd) begin
            for (int i = 0; i < col; i++) acc[i] <= sum[i];
        end
    end

endmodule
